// File: rtl/pipeline_arbiter_pkg.sv
// Shared state type and width helper for pipeline_arbiter.
package pipeline_arbiter_pkg;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } PIPELINE_ARB_STATE_T;

   function automatic int safeClog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority picker: lowest request at or above iPTR wins, wrapping.
module rr_priority_select #(
   parameter int P_N          = 4,
   parameter int P_SRC_W      = 2,
   parameter bit P_FIXED_PRIO = 1'b0
)(
   input  logic [P_N-1:0]     iREQ,
   input  logic [P_SRC_W-1:0] iPTR,
   output logic [P_N-1:0]     oGRANT,
   output logic [P_SRC_W-1:0] oIDX,
   output logic               oANY
);

   logic [2*P_N-1:0]   dbl;
   logic [2*P_N-1:0]   masked;
   logic [P_SRC_W-1:0] effPtr;

   always_comb begin
      effPtr = P_FIXED_PRIO ? '0 : iPTR;
      dbl    = {iREQ, iREQ};
      masked = dbl & ({(2*P_N){1'b1}} << effPtr);
      oIDX   = '0;
      // downward scan: the last hit assigned is the lowest masked bit, i.e. the wrap winner
      for (int k = 2*P_N-1; k >= 0; k--) begin
         if (masked[k]) oIDX = P_SRC_W'(k % P_N);
      end
      oANY   = |iREQ;
      oGRANT = oANY ? (P_N'(1) << oIDX) : '0;
   end

endmodule

// File: rtl/pipeline_arbiter.sv
// Shares one registered valid/busy stage among P_N requesters with round-robin and packet lock.
// Define PIPELINE_ARBITER_FIXED_PRIORITY_EN for fixed lowest-index-first arbitration.
module pipeline_arbiter
   import pipeline_arbiter_pkg::*;
#(
   parameter int P_N      = 4,
   parameter int P_DATA_W = 32,
   parameter int P_SRC_W  = safeClog2(P_N)
)(
   input  logic                    iCLOCK,
   input  logic                    inRESET,
   input  logic                    iFLUSH,
   input  logic [P_N-1:0]          iREQ_VALID,
   input  logic [P_N-1:0]          iREQ_LOCK,
   input  logic [P_N*P_DATA_W-1:0] iREQ_DATA,
   output logic [P_N-1:0]          oREQ_BUSY,
   output logic                    oNEXT_VALID,
   input  logic                    iNEXT_BUSY,
   output logic [P_DATA_W-1:0]     oNEXT_DATA,
   output logic [P_SRC_W-1:0]      oNEXT_SRC,
   output logic                    oLOCKED
);

   PIPELINE_ARB_STATE_T state, stateNext;
   logic [P_SRC_W-1:0]  owner, ownerNext;
   logic [P_SRC_W-1:0]  ptr;
   logic [P_SRC_W-1:0]  selIdx, winIdx;
   logic [P_N-1:0]      selGrant, winOneHot;
   logic                selAny, winValid, stall;
   logic [P_DATA_W-1:0] winData;
   logic                vld_p0;
   logic [P_DATA_W-1:0] data_p0;
   logic [P_SRC_W-1:0]  src_p0;

   function automatic logic [P_SRC_W-1:0] incWrap(input logic [P_SRC_W-1:0] idx);
      return (idx == P_SRC_W'(P_N - 1)) ? '0 : idx + 1'b1;
   endfunction

`ifdef PIPELINE_ARBITER_FIXED_PRIORITY_EN
   localparam bit FIXED_PRIO = 1'b1;
   assign ptr = '0;
`else
   localparam bit FIXED_PRIO = 1'b0;
   // the pointer moves past a requester only when its packet ends
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET)                               ptr <= '0;
      else if (winValid && !iREQ_LOCK[winIdx])    ptr <= incWrap(winIdx);
   end
`endif

   rr_priority_select #(
      .P_N          (P_N),
      .P_SRC_W      (P_SRC_W),
      .P_FIXED_PRIO (FIXED_PRIO)
   ) uSelect (
      .iREQ   (iREQ_VALID),
      .iPTR   (ptr),
      .oGRANT (selGrant),
      .oIDX   (selIdx),
      .oANY   (selAny)
   );

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state <= ARB;
         owner <= '0;
      end else begin
         state <= stateNext;
         owner <= ownerNext;
      end
   end

   always_comb begin
      stateNext = state;
      ownerNext = owner;
      stall     = iFLUSH | iNEXT_BUSY;
      winValid  = 1'b0;
      winIdx    = owner;
      winOneHot = '0;
      if (!stall) begin
         if (state == LOCKED) begin
            winValid  = iREQ_VALID[owner];
            winOneHot = winValid ? (P_N'(1) << owner) : '0;
         end else begin
            winValid  = selAny;
            winIdx    = selIdx;
            winOneHot = selGrant;
         end
      end
      if (iFLUSH) begin
         stateNext = ARB;
         ownerNext = '0;
      end else if (winValid) begin
         if (state == ARB && iREQ_LOCK[winIdx]) begin
            stateNext = LOCKED;
            ownerNext = winIdx;
         end else if (state == LOCKED && !iREQ_LOCK[winIdx]) begin
            stateNext = ARB;
         end
      end
      oREQ_BUSY = ~winOneHot;
   end

   assign winData = iREQ_DATA[winIdx*P_DATA_W +: P_DATA_W];

   // p0: registered output stage
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         vld_p0  <= 1'b0;
         data_p0 <= '0;
         src_p0  <= '0;
      end else if (iFLUSH) begin
         vld_p0  <= 1'b0;
      end else if (!iNEXT_BUSY) begin
         vld_p0 <= winValid;
         if (winValid) begin
            data_p0 <= winData;
            src_p0  <= winIdx;
         end
      end
   end

   assign oNEXT_VALID = vld_p0;
   assign oNEXT_DATA  = data_p0;
   assign oNEXT_SRC   = src_p0;
   assign oLOCKED     = (state == LOCKED);

endmodule

// File: tb/tb_pipeline_arbiter.sv
// Directed self-checking bench for pipeline_arbiter (P_N=4, P_DATA_W=32).
module tb_pipeline_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   logic          iCLOCK = 1'b0;
   logic          inRESET;
   logic          iFLUSH;
   logic          iNEXT_BUSY;
   logic [N-1:0]  iREQ_VALID;
   logic [N-1:0]  iREQ_LOCK;
   logic [N*DW-1:0] iREQ_DATA;
   logic [N-1:0]  oREQ_BUSY;
   logic          oNEXT_VALID;
   logic [DW-1:0] oNEXT_DATA;
   logic [SW-1:0] oNEXT_SRC;
   logic          oLOCKED;

   int checks = 0;
   int errors = 0;

   always #5 iCLOCK = ~iCLOCK;

   pipeline_arbiter #(.P_N(N), .P_DATA_W(DW)) dut (
      .iCLOCK      (iCLOCK),
      .inRESET     (inRESET),
      .iFLUSH      (iFLUSH),
      .iREQ_VALID  (iREQ_VALID),
      .iREQ_LOCK   (iREQ_LOCK),
      .iREQ_DATA   (iREQ_DATA),
      .oREQ_BUSY   (oREQ_BUSY),
      .oNEXT_VALID (oNEXT_VALID),
      .iNEXT_BUSY  (iNEXT_BUSY),
      .oNEXT_DATA  (oNEXT_DATA),
      .oNEXT_SRC   (oNEXT_SRC),
      .oLOCKED     (oLOCKED)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [3:0] v, input logic [3:0] l,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] d3);
      iREQ_VALID = v;
      iREQ_LOCK  = l;
      iREQ_DATA  = {d3, d2, d1, d0};
   endtask

   task automatic tick;
      @(posedge iCLOCK);
      #1;
   endtask

   task automatic expBusy(input string tag, input logic [3:0] e);
      checkVal({tag, "_busy"}, 32'(oREQ_BUSY), 32'(e));
   endtask

   task automatic expOut(input string tag, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic lk);
      checkVal({tag, "_vld"},  32'(oNEXT_VALID), 32'(v));
      checkVal({tag, "_src"},  32'(oNEXT_SRC),   32'(s));
      checkVal({tag, "_data"}, oNEXT_DATA,       d);
      checkVal({tag, "_lock"}, 32'(oLOCKED),     32'(lk));
   endtask

   initial begin
      inRESET    = 1'b0;
      iFLUSH     = 1'b0;
      iNEXT_BUSY = 1'b0;
      drive(4'b0000, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      expOut("reset", 1'b0, 2'd0, 32'h0, 1'b0);
      tick;
      tick;
      inRESET = 1'b1;

`ifdef PIPELINE_ARBITER_FIXED_PRIORITY_EN
      drive(4'b1010, 4'b0000, 32'h0, 32'hA1, 32'h0, 32'hA3);
      for (int k = 0; k < 4; k++) begin
         #1;
         expBusy("fixed", 4'b1101);
         tick;
         expOut("fixed", 1'b1, 2'd1, 32'hA1, 1'b0);
      end
`else
      // rotation through all four requesters
      drive(4'b1111, 4'b0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
      for (int k = 0; k < 5; k++) begin
         #1;
         expBusy("rr", ~(4'b0001 << (k % 4)));
         tick;
         expOut("rr", 1'b1, 2'(k % 4), 32'hA0 + 32'(k % 4), 1'b0);
      end

      // packet lock from requester 2 while requester 0 waits (pointer is 1)
      drive(4'b0101, 4'b0100, 32'hA0, 32'h0, 32'h10, 32'h0);
      #1; expBusy("lk0", 4'b1011);
      checkVal("lk0_pre", 32'(oLOCKED), 32'h0);
      tick; expOut("lk0", 1'b1, 2'd2, 32'h10, 1'b1);
      drive(4'b0101, 4'b0100, 32'hA0, 32'h0, 32'h11, 32'h0);
      #1; expBusy("lk1", 4'b1011);
      tick; expOut("lk1", 1'b1, 2'd2, 32'h11, 1'b1);
      drive(4'b0101, 4'b0000, 32'hA0, 32'h0, 32'h12, 32'h0);
      #1; expBusy("lk2", 4'b1011);
      tick; expOut("lk2", 1'b1, 2'd2, 32'h12, 1'b0);
      drive(4'b0001, 4'b0000, 32'hA0, 32'h0, 32'h0, 32'h0);
      #1; expBusy("lk3", 4'b1110);
      tick; expOut("lk3", 1'b1, 2'd0, 32'hA0, 1'b0);

      // downstream stall: outputs frozen, pointer (1) must not move; lock on idle req0 ignored
      drive(4'b1110, 4'b0001, 32'h0, 32'hA1, 32'hA2, 32'hA3);
      iNEXT_BUSY = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1; expBusy("stall", 4'b1111);
         tick; expOut("stall", 1'b1, 2'd0, 32'hA0, 1'b0);
      end
      iNEXT_BUSY = 1'b0;
      #1; expBusy("resume", 4'b1101);
      tick; expOut("resume", 1'b1, 2'd1, 32'hA1, 1'b0);

      // lock owner 1, then flush together with downstream busy (pointer is 2)
      drive(4'b0010, 4'b0010, 32'h0, 32'h21, 32'h0, 32'h0);
      #1; expBusy("own1", 4'b1101);
      tick; expOut("own1", 1'b1, 2'd1, 32'h21, 1'b1);
      drive(4'b1010, 4'b0010, 32'h0, 32'h21, 32'h0, 32'hA3);
      iFLUSH     = 1'b1;
      iNEXT_BUSY = 1'b1;
      #1; expBusy("flush", 4'b1111);
      tick; expOut("flush", 1'b0, 2'd1, 32'h21, 1'b0);
      iFLUSH     = 1'b0;
      iNEXT_BUSY = 1'b0;
      #1; expBusy("postfl", 4'b0111);
      tick; expOut("postfl", 1'b1, 2'd3, 32'hA3, 1'b0);

      // locked owner 0 goes idle: others ignored, output bubbles (pointer is 0)
      drive(4'b1001, 4'b0001, 32'h30, 32'h0, 32'h0, 32'hA3);
      #1; expBusy("own0", 4'b1110);
      tick; expOut("own0", 1'b1, 2'd0, 32'h30, 1'b1);
      drive(4'b1000, 4'b0001, 32'h30, 32'h0, 32'h0, 32'hA3);
      #1; expBusy("idle", 4'b1111);
      tick; expOut("idle", 1'b0, 2'd0, 32'h30, 1'b1);
      drive(4'b0001, 4'b0000, 32'h31, 32'h0, 32'h0, 32'h0);
      #1; expBusy("last0", 4'b1110);
      tick; expOut("last0", 1'b1, 2'd0, 32'h31, 1'b0);

      // asynchronous reset while locked on requester 2 (pointer is 1 before reset)
      drive(4'b0100, 4'b0100, 32'h0, 32'h0, 32'h40, 32'h0);
      #1; expBusy("own2", 4'b1011);
      tick; expOut("own2", 1'b1, 2'd2, 32'h40, 1'b1);
      #2 inRESET = 1'b0;
      #1; expOut("arst", 1'b0, 2'd0, 32'h0, 1'b0);
      tick; expOut("arst_hold", 1'b0, 2'd0, 32'h0, 1'b0);
      #2 inRESET = 1'b1;
      drive(4'b1111, 4'b0000, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
      #1; expBusy("first", 4'b1110);
      tick; expOut("first", 1'b1, 2'd0, 32'hA0, 1'b0);

      // requesters 1 and 3 share fairly
      drive(4'b1010, 4'b0000, 32'h0, 32'hA1, 32'h0, 32'hA3);
      for (int k = 0; k < 4; k++) begin
         #1; expBusy("alt", (k % 2 == 0) ? 4'b1101 : 4'b0111);
         tick;
         expOut("alt", 1'b1, (k % 2 == 0) ? 2'd1 : 2'd3,
                (k % 2 == 0) ? 32'hA1 : 32'hA3, 1'b0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_arbiter.md
Name: pipeline_arbiter

Overview:
- Shares one registered valid/busy pipeline stage among P_N upstream requesters.
- Round-robin arbitration, with optional multi-beat lock so a requester keeps the grant for a packet.
- Sits between parallel producers (e.g. fetch/load ports) and a single downstream pipeline consumer.
- Output is registered, giving 1 cycle of latency, with the same valid/busy semantics as the team's pipeline stages.

Parameters:
P_N, 4, number of requesters (2..8)
P_DATA_W, 32, payload width per requester
P_SRC_W, $clog2(P_N), width of source index (derived; minimum 1)

Ports:
iCLOCK  in  1  clock, rising edge
inRESET  in  1  asynchronous active-low reset
iFLUSH  in  1  synchronous flush: drop output beat, release lock
iREQ_VALID  in  P_N  per-requester valid
iREQ_LOCK  in  P_N  per-requester "more beats follow, keep grant"
iREQ_DATA  in  P_N*P_DATA_W  payloads; requester i occupies bits [i*P_DATA_W +: P_DATA_W]
oREQ_BUSY  out  P_N  per-requester busy (backpressure)
oNEXT_VALID  out  1  registered output valid
iNEXT_BUSY  in  1  downstream busy
oNEXT_DATA  out  P_DATA_W  registered payload
oNEXT_SRC  out  P_SRC_W  index of requester that supplied the current output beat
oLOCKED  out  1  arbiter is in LOCKED state

Behaviour:
- Clock and reset: one clock iCLOCK; reset inRESET is asynchronous, active-low.
- Reset values:
  - oNEXT_VALID=0, oNEXT_DATA=0, oNEXT_SRC=0, oLOCKED=0.
  - RR pointer=0, owner=0, state=ARB.
- Reset behaviour: assertion mid-transfer clears all state immediately; no beat survives.
- Transfer definition: requester i transfers in a cycle when iREQ_VALID[i] && !oREQ_BUSY[i]. Requesters hold valid, data and lock stable while busy.
- Winner selection (combinational):
  - Skipped entirely if iFLUSH or iNEXT_BUSY is high.
  - ARB: first valid requester found scanning upward from the RR pointer, wrapping P_N-1 -> 0.
  - LOCKED: the owner only, and only if it is valid. Other requesters are ignored even if valid.
- oREQ_BUSY[i]=0 only for the winner; every other requester sees 1. With iNEXT_BUSY=1 or iFLUSH=1, all are 1.
- Output register:
  - iFLUSH: oNEXT_VALID<=0.
  - Else if !iNEXT_BUSY: oNEXT_VALID<=(winner exists). On a winner, oNEXT_DATA<=winner data and oNEXT_SRC<=winner index.
  - Else (iNEXT_BUSY=1): hold all output registers.
  - Data and src are not updated when there is no winner.
- State machine, two states: ARB, LOCKED.
  - ARB, transfer from i with iREQ_LOCK[i]=1: go to LOCKED, owner<=i. The pointer is not changed.
  - ARB, transfer from i with lock=0: stay in ARB, pointer<=(i+1) mod P_N.
  - LOCKED, owner transfer with lock=1: stay in LOCKED.
  - LOCKED, owner transfer with lock=0 (last beat): go to ARB, pointer<=(owner+1) mod P_N.
  - LOCKED with owner not valid: stay in LOCKED; output valid goes 0 if downstream is not busy.
  - iFLUSH in any state: go to ARB, owner<=0, pointer unchanged. No transfer occurs that cycle.
- Simultaneous events:
  - iFLUSH with iNEXT_BUSY=1: flush wins and oNEXT_VALID clears.
  - iREQ_LOCK is ignored while iREQ_VALID is 0.
- oLOCKED = (state==LOCKED).

Optional Feature:
- Macro: PIPELINE_ARBITER_FIXED_PRIORITY_EN.
- Defined:
  - ARB selection is fixed priority; the lowest index wins.
  - The RR pointer register is removed; the pointer is treated as constantly 0.
  - Lock behaviour is unchanged.
- Undefined: round-robin as described under Behaviour.
- Ports are identical in both builds.

Decomposition:
- Package pipeline_arbiter_pkg:
  - State enum PIPELINE_ARB_STATE_T {ARB, LOCKED}.
  - Function computing safe clog2 (minimum 1) for P_SRC_W.
- Sub-module rr_priority_select, purely combinational:
  - Inputs: request vector, pointer, and a fixed-priority mode parameter.
  - Outputs: one-hot grant plus encoded index, using double-width mask-and-wrap.
- The FSM, pointer and output register stay in pipeline_arbiter.

Test Plan:
- Reset, then all requesters valid with distinct data (0xA0..0xA3), lock=0, iNEXT_BUSY=0 -> oNEXT_SRC sequence 0,1,2,3,0 on consecutive cycles, each oNEXT_DATA matching its source, oNEXT_VALID continuously 1.
- Requester 2 valid with lock=1 for beats 0x10,0x11, then lock=0 for 0x12, requester 0 valid throughout -> three consecutive beats src=2, oLOCKED=1 for two cycles, oREQ_BUSY[0]=1, then src=0 next.
- Transfer pending, iNEXT_BUSY=1 held 3 cycles -> oNEXT_VALID/DATA/SRC frozen, all oREQ_BUSY=1, no pointer advance; resumes with the same winner after release.
- In LOCKED (owner 1), assert iFLUSH one cycle with iNEXT_BUSY=1 -> oNEXT_VALID=0 next cycle, oLOCKED=0, requester 3 granted on the following cycle.
- Deassert inRESET asynchronously mid-stream (between clock edges) -> oNEXT_VALID=0 and oLOCKED=0 immediately; after release, first grant goes to requester 0.
- Build with PIPELINE_ARBITER_FIXED_PRIORITY_EN, requesters 1 and 3 continuously valid -> src=1 every cycle, requester 3 starved.
